// File: rtl/ccff_cfg_pkg.sv
// Shared types and constants for the ccff configuration chain loader.
package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } ccff_ld_state_e;

    // Default chain lengths per tile type.
    localparam int unsigned CLB_CHAIN_LEN = 1024;
    localparam int unsigned IO_CHAIN_LEN  = 64;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// WORD_W shift register with a remaining-bit counter; presents bit 0 first.
module ccff_word_serializer
    import ccff_cfg_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REM_W  = clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [REM_W-1:0]  count,
    input  logic              shift,
    output logic              bit_out,
    output logic              last
);

    logic [WORD_W-1:0] sreg;
    logic [REM_W-1:0]  remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg      <= '0;
            remaining <= '0;
        end else if (load) begin
            sreg      <= data;
            remaining <= count;
        end else if (shift) begin
            sreg <= sreg >> 1;
            if (remaining != '0) remaining <= remaining - REM_W'(1);
        end
    end

    assign bit_out = sreg[0];
    assign last    = (remaining == REM_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words into the ccff chain and gates prog_clk via ccff_shift_en.
// Optional destructive readback of ccff_tail: define CCFF_CHAIN_READBACK_EN.
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter  int unsigned WORD_W    = 32,
    parameter  int unsigned CHAIN_LEN = CLB_CHAIN_LEN,
    localparam int unsigned CNT_W     = clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_CHAIN_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int unsigned REM_W = clog2(WORD_W + 1);

    ccff_ld_state_e   state;
    logic             handshake;
    logic             word_last;
    logic             final_shift;
    logic [REM_W-1:0] word_count;
    int unsigned      bits_left;

    assign handshake   = cfg_valid & cfg_ready;
    assign final_shift = (bit_count == CNT_W'(CHAIN_LEN - 1));

    always_comb begin
        bits_left  = CHAIN_LEN - 32'(bit_count);
        word_count = REM_W'((bits_left < WORD_W) ? bits_left : WORD_W);
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .REM_W  (REM_W)
    ) u_serializer (
        .clk     (prog_clk),
        .reset   (prog_reset),
        .load    (handshake),
        .data    (cfg_data),
        .count   (word_count),
        .shift   (ccff_shift_en),
        .bit_out (ccff_head),
        .last    (word_last)
    );

    // ccff_shift_en is set on entry to SHIFT, so it mirrors the state with no decode glitch.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state         <= IDLE;
            cfg_ready     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bit_count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= FETCH;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bit_count <= '0;
                    end
                end
                FETCH: begin
                    if (handshake) begin
                        state         <= SHIFT;
                        cfg_ready     <= 1'b0;
                        ccff_shift_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_count != CNT_W'(CHAIN_LEN)) bit_count <= bit_count + CNT_W'(1);
                    if (final_shift) begin
                        state         <= DONE;
                        ccff_shift_en <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else if (word_last) begin
                        state         <= FETCH;
                        ccff_shift_en <= 1'b0;
                        cfg_ready     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CCFF_CHAIN_READBACK_EN
    localparam int unsigned IDX_W = clog2(WORD_W);

    logic [WORD_W-1:0] rb_acc;
    logic [WORD_W-1:0] rb_word;
    logic [IDX_W-1:0]  rb_cnt;

    always_comb begin
        rb_word         = rb_acc;
        rb_word[rb_cnt] = ccff_tail;
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_acc   <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (ccff_shift_en) begin
                if (rb_cnt == IDX_W'(WORD_W - 1) || final_shift) begin
                    rb_data  <= rb_word;
                    rb_valid <= 1'b1;
                    rb_acc   <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_acc <= rb_word;
                    rb_cnt <= rb_cnt + IDX_W'(1);
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench: two loaders (64- and 40-bit chains) share stimulus; behavioural chain models feed ccff_tail.
module tb_ccff_chain_loader;

    logic        clk = 1'b0;
    logic        prog_reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;

    logic       rdy64, head64, sh64, busy64, done64;
    logic [6:0] bc64;
    logic       rdy40, head40, sh40, busy40, done40;
    logic [5:0] bc40;

    logic [63:0] chain64 = '0;
    logic [39:0] chain40 = '0;
    logic [63:0] pre64 = '0;
    logic [39:0] pre40 = '0;
    logic        pre_req = 1'b0;

`ifdef CCFF_CHAIN_READBACK_EN
    logic [31:0] rbd64, rbd40;
    logic        rbv64, rbv40;
    logic [31:0] rb_q64[$];
    logic [31:0] rb_q40[$];
`endif

    always #5 clk = ~clk;

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut64 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy64),
        .ccff_head(head64), .ccff_shift_en(sh64), .ccff_tail(chain64[0]),
        .busy(busy64), .done(done64), .bit_count(bc64)
`ifdef CCFF_CHAIN_READBACK_EN
        , .rb_data(rbd64), .rb_valid(rbv64)
`endif
    );

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut40 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy40),
        .ccff_head(head40), .ccff_shift_en(sh40), .ccff_tail(chain40[0]),
        .busy(busy40), .done(done40), .bit_count(bc40)
`ifdef CCFF_CHAIN_READBACK_EN
        , .rb_data(rbd40), .rb_valid(rbv40)
`endif
    );

    // Chain flops: head enters at the top, tail is bit 0, so image bit k ends in chain[k].
    always @(posedge clk) begin
        if (pre_req) begin
            chain64 <= pre64;
            chain40 <= pre40;
        end else begin
            if (sh64) chain64 <= {head64, chain64[63:1]};
            if (sh40) chain40 <= {head40, chain40[39:1]};
        end
    end

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   tot64 = 0, tot40 = 0, base64 = 0, base40 = 0;
    int   first64 = 0, last64 = 0, start_cyc = 0;
    bit   mon_on = 1'b0;
    logic head_q64[$];
    logic head_q40[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_on) begin
            check("bit_count64_track", 64'(bc64), 64'(tot64 - base64));
            check("bit_count40_track", 64'(bc40), 64'(tot40 - base40));
            check("ready_shen_excl64", 64'(rdy64 & sh64), 64'd0);
            check("ready_shen_excl40", 64'(rdy40 & sh40), 64'd0);
        end
        if (sh64 === 1'b1) begin
            if (tot64 == base64) first64 = cyc;
            last64 = cyc;
            head_q64.push_back(head64);
            tot64++;
        end
        if (sh40 === 1'b1) begin
            head_q40.push_back(head40);
            tot40++;
        end
`ifdef CCFF_CHAIN_READBACK_EN
        if (rbv64 === 1'b1) rb_q64.push_back(rbd64);
        if (rbv40 === 1'b1) rb_q40.push_back(rbd40);
`endif
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc - 1;
        base64 = tot64;
        base40 = tot40;
        check("busy_after_start", 64'(busy64), 64'd1);
        check("bit_count_cleared", 64'(bc64), 64'd0);
        check("ready_in_fetch", 64'(rdy64), 64'd1);
    endtask

    // Waits for FETCH, optionally withholds cfg_valid for `hold` cycles, then hands the word over.
    task automatic push_word(input logic [31:0] w, input int unsigned hold);
        int g;
        logic [63:0] snap;
        if (hold > 0) begin
            cfg_valid = 1'b0;
            g = 0;
            while (!(rdy64 || rdy40) && g < 200) begin tick(); g++; end
            check("fetch_reached", 64'(rdy64 | rdy40), 64'd1);
            snap = chain64;
            for (int unsigned i = 0; i < hold; i++) begin
                tick();
                check("gap_shift_en_low", 64'(sh64), 64'd0);
                check("gap_ready_high", 64'(rdy64), 64'd1);
            end
            check("gap_chain_held", chain64, snap);
        end
        cfg_data = w;
        cfg_valid = 1'b1;
        g = 0;
        while (!(rdy64 || rdy40) && g < 200) begin tick(); g++; end
        check("handshake_ready", 64'(rdy64 | rdy40), 64'd1);
        tick();
        cfg_data = $urandom();
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input int unsigned h0,
                        input int unsigned h1, input bit span, input bit noise);
        int g;
        logic [63:0] got64;
        logic [39:0] got40;
        begin_load();
        push_word(w0, h0);
        push_word(w1, h1);
        g = 0;
        while (!(done64 && done40) && g < 300) begin
            start = (noise && !done64 && !done40) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            g++;
        end
        start = 1'b0;
        check("done64", 64'(done64), 64'd1);
        check("done40", 64'(done40), 64'd1);
        check("final_bit_count64", 64'(bc64), 64'd64);
        check("final_bit_count40", 64'(bc40), 64'd40);
        check("busy_cleared", 64'({busy64, busy40}), 64'd0);
        check("ready_low_done", 64'({rdy64, rdy40}), 64'd0);
        check("shift_total64", 64'(tot64 - base64), 64'd64);
        check("shift_total40", 64'(tot40 - base40), 64'd40);
        got64 = '0;
        got40 = '0;
        for (int i = 0; i < 64; i++) if (base64 + i < head_q64.size()) got64[i] = head_q64[base64 + i];
        for (int i = 0; i < 40; i++) if (base40 + i < head_q40.size()) got40[i] = head_q40[base40 + i];
        check("head_image64", got64, {w1, w0});
        check("head_image40", 64'(got40), 64'({w1[7:0], w0}));
        check("chain_image64", chain64, {w1, w0});
        check("chain_image40", 64'(chain40), 64'({w1[7:0], w0}));
        check("start_latency_ge2", 64'((first64 - start_cyc) >= 2), 64'd1);
        if (span) check("shift_span64", 64'(last64 - first64 + 1), 64'd65);
    endtask

    initial begin
        int g;
        logic [31:0] r0, r1;
        repeat (3) tick();
        prog_reset = 1'b0;
        check("rst_outputs64", 64'({rdy64, head64, sh64, busy64, done64}), 64'd0);
        check("rst_outputs40", 64'({rdy40, head40, sh40, busy40, done40}), 64'd0);
        check("rst_bit_count64", 64'(bc64), 64'd0);
        check("rst_bit_count40", 64'(bc40), 64'd0);
        base64 = tot64;
        base40 = tot40;
        mon_on = 1'b1;

        // Back-to-back words with cfg_valid held high.
        load(32'hA5A5_0F0F, 32'h1234_5678, 0, 0, 1'b1, 1'b0);
        // Ten-cycle stall before the second word.
        load($urandom(), $urandom(), 0, 10, 1'b0, 1'b0);

        // Reset in the middle of a load.
        begin_load();
        cfg_data = $urandom();
        cfg_valid = 1'b1;
        g = 0;
        while (bc64 != 7'd17 && g < 100) begin tick(); g++; end
        check("reached_17", 64'(bc64), 64'd17);
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        cfg_valid = 1'b0;
        check("midrst_busy", 64'({busy64, busy40}), 64'd0);
        check("midrst_shift_en", 64'({sh64, sh40}), 64'd0);
        check("midrst_bit_count64", 64'(bc64), 64'd0);
        check("midrst_bit_count40", 64'(bc40), 64'd0);
        check("midrst_ready_done", 64'({rdy64, done64, rdy40, done40}), 64'd0);
        base64 = tot64;
        base40 = tot40;
        load($urandom(), $urandom(), 0, 0, 1'b1, 1'b0);

        // Start pulses while busy, then a clean reload from DONE.
        load($urandom(), $urandom(), 1, 2, 1'b0, 1'b1);
        load($urandom(), $urandom(), 0, 0, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            r0 = $urandom();
            r1 = $urandom();
            load(r0, r1, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef CCFF_CHAIN_READBACK_EN
        begin
            int b64, b40;
            pre64 = 64'hDEAD_BEEF_CAFE_F00D;
            pre40 = {8'($urandom()), 32'($urandom())};
            pre_req = 1'b1;
            tick();
            pre_req = 1'b0;
            b64 = rb_q64.size();
            b40 = rb_q40.size();
            load(32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
            check("rb_count64", 64'(rb_q64.size() - b64), 64'd2);
            check("rb_count40", 64'(rb_q40.size() - b40), 64'd2);
            if (rb_q64.size() >= b64 + 2) begin
                check("rb64_word0", 64'(rb_q64[b64]), 64'hCAFE_F00D);
                check("rb64_word1", 64'(rb_q64[b64 + 1]), 64'hDEAD_BEEF);
            end
            if (rb_q40.size() >= b40 + 2) begin
                check("rb40_word0", 64'(rb_q40[b40]), 64'(pre40[31:0]));
                check("rb40_word1", 64'(rb_q40[b40 + 1]), 64'(pre40[39:32]));
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
